// File: rtl/cpu_trace_capture_pkg.sv
// Shared types and constants for the CPU trace capture unit: state encoding,
// record layout and field offsets.
package cpu_trace_pkg;

    localparam int unsigned REC_W       = 71;
    localparam int unsigned WDATA_LSB   = 0;
    localparam int unsigned WREG_LSB    = 32;
    localparam int unsigned REGWRE_BIT  = 37;
    localparam int unsigned MWR_BIT     = 38;
    localparam int unsigned PC_LSB      = 39;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // One commit record; field order matches the offsets above (MSB first)
    typedef struct packed {
        logic [31:0] pc;
        logic        mwr;
        logic        regwre;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } trace_rec_t;

endpackage

// File: rtl/cpu_trace_capture_if.sv
// Valid/ready read port carrying trace records out of the capture unit.
interface cpu_trace_capture_if;
    import cpu_trace_pkg::*;

    logic             rd_valid;
    logic             rd_ready;
    logic [REC_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/cpu_trace_capture_trace_fifo.sv
// Synchronous single-clock FIFO with a registered head output that already
// holds the next entry after a pop, so back-to-back reads have no bubble.
module trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 71
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic [WIDTH-1:0] head_n;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rd_ptr_n = rd_ptr + AW'(do_pop);

    // A push into the slot that becomes the head bypasses the array
    assign head_n = (do_push && (wr_ptr == rd_ptr_n)) ? din : mem[rd_ptr_n];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr_n;
            count  <= count + CW'(do_push) - CW'(do_pop);
            head   <= head_n;
        end
    end

endmodule

// File: rtl/cpu_trace_capture.sv
// Trace capture beside the MIPS CPU: PC-triggered commit recording, drained in
// FIFO order over a valid/ready port. Define CPU_TRACE_FILTER_EN to keep only
// commits that write a register or memory.
module cpu_trace_capture
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   stop,
    input  logic [31:0]            trig_pc,
    input  logic [31:0]            pcOut,
    input  logic                   PCWre,
    input  logic                   RegWre,
    input  logic [4:0]             WriteReg,
    input  logic [31:0]            writeData,
    input  logic                   mWR,
    cpu_trace_capture_if.master    rd,
    output state_t                 state,
    output logic [$clog2(DEPTH):0] count,
    output logic                   triggered
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   trig_pc_q;
    logic          rd_valid_q;
    trace_rec_t    rec;
    logic          keep;
    logic          hit;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count_n;
    logic          fill_done;
    logic          done_next;

    assign rec = '{pc: pcOut, mwr: mWR, regwre: RegWre, wreg: WriteReg, wdata: writeData};

`ifdef CPU_TRACE_FILTER_EN
    assign keep = RegWre || mWR;
`else
    assign keep = 1'b1;
`endif

    // A stop in the same cycle as a trigger hit wins: the session ends empty
    assign hit       = (state == ARMED) && !stop && PCWre && (pcOut == trig_pc_q);
    assign push      = hit || ((state == CAPTURE) && PCWre && keep && !full);
    assign pop       = rd_valid_q && rd.rd_ready && !empty;
    assign count_n   = count + CW'(push) - CW'(pop);
    assign fill_done = push && (count_n == CW'(DEPTH));
    assign done_next = ((state == ARMED) && stop)
                    || ((state == CAPTURE) && (stop || fill_done))
                    || ((state == DONE) && (count_n != '0));

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (rec),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (rd.rd_data)
    );

    assign rd.rd_valid = rd_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            trig_pc_q  <= '0;
            triggered  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= done_next && (count_n != '0);
            case (state)
                IDLE: begin
                    if (arm) begin
                        state     <= ARMED;
                        trig_pc_q <= trig_pc;
                        triggered <= 1'b0;
                    end
                end
                ARMED: begin
                    if (stop) begin
                        state <= DONE;
                    end else if (hit) begin
                        state     <= CAPTURE;
                        triggered <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (stop || fill_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (count_n == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_trace_capture.md
# cpu_trace_capture

Trace capture unit for the single-cycle MIPS CPU: snoops the CPU debug outputs (program counter, register write-back, memory write strobe), starts recording on a programmable PC trigger and stores one commit record per executed instruction in an internal buffer. After capture, the records are drained through a valid/ready read port. It sits beside `CPU` in the test top and is the reader for the CPU's debug output port.

## Interface
- `DEPTH`, 16: number of trace records stored; power of two, at least 2.
- `clk` input 1: single clock, shared with `CPU`.
- `reset` input 1: synchronous, active-high; clears all state.
- `arm` input 1: single-cycle pulse; starts a capture session. Only acts in IDLE.
- `stop` input 1: forces the end of capture. Acts in ARMED or CAPTURE.
- `trig_pc` input 32: PC value that starts recording. Sampled when `arm` is accepted.
- `pcOut` input 32: current CPU PC.
- `PCWre` input 1: the instruction commits this cycle.
- `RegWre` input 1: register write enable.
- `WriteReg` input 5: destination register.
- `writeData` input 32: write-back data.
- `mWR` input 1: data-memory write strobe.
- `rd_valid` output 1: a record is available on `rd_data`.
- `rd_ready` input 1: consumer accepts the record.
- `rd_data` output 71: record `{pc[31:0], mWR, RegWre, WriteReg[4:0], writeData[31:0]}`.
- `state` output 2: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- `count` output clog2(DEPTH)+1: number of records held.
- `triggered` output 1: sticky. Set when the trigger PC was hit in this session.

## Operation
- State IDLE to ARMED on `arm`. Latches `trig_pc` and clears `triggered`. The buffer is empty on entry.
- In ARMED, a cycle with `PCWre && pcOut == trig_pc_q` is a hit:
  - the hit cycle's record is written;
  - `triggered` is set;
  - the state moves to CAPTURE.
- In CAPTURE, every cycle with `PCWre=1` writes one record (subject to the configured filter).
- The state moves from CAPTURE to DONE in either case:
  - the write that makes `count == DEPTH`;
  - `stop` is asserted. A record qualifying in that same cycle is still written if there is space.
- `stop` in ARMED moves the state to DONE with zero records and `triggered=0`.
- DONE: `rd_valid = (count != 0)`; `rd_data` is the oldest record. The read port is FIFO order.
  - A pop happens on `rd_valid && rd_ready`.
  - When the pop removes the last record, the state is IDLE on the next cycle.
  - If DONE is entered with `count==0`, the state returns to IDLE on the next cycle.
- `arm` outside IDLE is ignored. No writes occur outside ARMED/CAPTURE. `rd_valid=0` outside DONE.
- The buffer never overwrites: capture ends at full, so there is no wrap of unread data. Pointers wrap modulo DEPTH.

## Timing
- Reset values: `state=0`, `count=0`, `rd_valid=0`, `rd_data=0`, `triggered=0`. Pointers and `trig_pc_q` are 0.
- A record written at edge N is visible in `count` after edge N.
- `rd_data`/`rd_valid` are registered outputs. After a pop at edge N, the next record is presented after edge N, with no bubble.
- The trigger compare is a same-cycle equality on the registered `trig_pc_q`. A hit is recorded in the hit cycle itself.
- Reset asserted mid-session discards all records and returns to IDLE on the next edge. It has priority over `arm`, `stop` and pops.

## Configuration
- `CPU_TRACE_FILTER_EN` defined: in CAPTURE, a commit cycle is recorded only if `RegWre || mWR`. The trigger-hit record is always written.
- Undefined: every `PCWre` cycle in CAPTURE is recorded, and `mWR`/`RegWre` are stored as observed.

## Structure
- Package `cpu_trace_pkg` holds:
  - the state encoding (IDLE/ARMED/CAPTURE/DONE);
  - the record width constant (71);
  - the field offsets for pc, mWR, RegWre, WriteReg and writeData.
- Sub-module `trace_fifo` (parameter DEPTH, WIDTH): synchronous single-clock FIFO with push, pop, full, empty, count and a registered head output. The top holds the FSM, the trigger compare and the filter.

## Test plan
- Trigger hit: arm with `trig_pc=0x0000_0008`; CPU commits PCs 0, 4, 8, 0xC, 0x10; stop after 0x10. Expect DONE, `count=3`, reads 0x8, 0xC, 0x10 in order, `triggered=1`, then IDLE.
- Full: DEPTH=16, trigger at 0, 20 consecutive commits. Expect `count=16` and DONE on the 16th write; the record with PC 0x3C is the last; no further writes.
- Stop before hit: arm `trig_pc=0x100`, stop after 5 cycles. Expect DONE with `count=0`, `triggered=0`, IDLE one cycle later.
- Read backpressure: hold `rd_ready=0` for 4 cycles, then 1. Expect `rd_data` stable while stalled, then one record per cycle with no bubble.
- Reset mid-capture: assert `reset` with `count=5` in CAPTURE. Expect all outputs at reset values on the next edge.
- Filter (`CPU_TRACE_FILTER_EN`): commits alternate `RegWre=1` and a beq instruction. Expect only the RegWre records plus the trigger record to be stored.
